// File: rtl/risk_ctrl_pkg.sv
// Shared encodings for the RISC control FSM: opcodes, ALU ops, state codes, decode class flags.
package risk_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  typedef struct packed {
    logic alu;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic halt;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/risk_ctrl_fsm_if.sv
// Instruction/data memory req/ack handshake bundle; master is the control FSM, slave the memories.
interface risk_ctrl_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/risk_ctrl_decode.sv
// Combinational opcode classifier: class flags plus the ALU operation for EXEC.
module risk_ctrl_decode
  import risk_ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic [OPW-1:0]  op,
  output op_class_t       cls,
  output logic [ALUW-1:0] alu_op
);

  always_comb begin
    cls    = '0;
    alu_op = ALUW'(ALU_ADD);
    case (op)
      OP_ADD:  cls.alu = 1'b1;
      OP_SUB:  begin cls.alu = 1'b1; alu_op = ALUW'(ALU_SUB); end
      OP_AND:  begin cls.alu = 1'b1; alu_op = ALUW'(ALU_AND); end
      OP_OR:   begin cls.alu = 1'b1; alu_op = ALUW'(ALU_OR);  end
      OP_ADDI: cls.imm   = 1'b1;
      OP_LW:   cls.load  = 1'b1;
      OP_SW:   cls.store = 1'b1;
      OP_BEQ:  begin cls.branch = 1'b1; alu_op = ALUW'(ALU_SUB); end
      OP_HALT: cls.halt = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/risk_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer driving all datapath enables and selects.
// Optional retired-instruction counter enabled by RISK_CTRL_PERF_EN.
module risk_ctrl_fsm
  import risk_ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic            alu_zero,
  risk_ctrl_fsm_if.master mem,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            imm_sel,
  output logic [ALUW-1:0] alu_op,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            halted,
  output logic            illegal
`ifdef RISK_CTRL_PERF_EN
  , output logic [15:0]   retired
`endif
);

  logic [2:0]      state_q, state_d;
  logic [OPW-1:0]  op_q;
  logic [OPW-1:0]  dec_op;
  logic            illegal_q;
  op_class_t       cls;
  logic [ALUW-1:0] dec_alu_op;
  logic            imem_req_w, dmem_req_w, dmem_we_w;

  // DECODE steers on the live IR opcode; later states use the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

  risk_ctrl_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
    .op     (dec_op),
    .cls    (cls),
    .alu_op (dec_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        if (cls.illegal) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem.imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = (cls.halt || cls.illegal) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (cls.load || cls.store) state_d = S_MEM;
        else if (cls.branch)       state_d = S_FETCH;
        else                       state_d = S_WB;
      end
      S_MEM:    if (mem.dmem_ack) state_d = cls.load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_w = 1'b0;
    dmem_req_w = 1'b0;
    dmem_we_w  = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    imm_sel    = 1'b0;
    alu_op     = '0;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_w = 1'b1;
        ir_load    = mem.imem_ack;
        pc_inc     = mem.imem_ack;
      end
      S_EXEC: begin
        alu_op  = dec_alu_op;
        imm_sel = cls.imm | cls.load | cls.store;
        pc_load = cls.branch & alu_zero;
      end
      S_MEM: begin
        dmem_req_w = 1'b1;
        dmem_we_w  = cls.store;
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = cls.load;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.imem_req = imem_req_w;
  assign mem.dmem_req = dmem_req_w;
  assign mem.dmem_we  = dmem_we_w;
  assign illegal      = illegal_q;

`ifdef RISK_CTRL_PERF_EN
  logic [15:0] retired_q;
  logic        retire;

  // Counted on the exit cycle of each instruction's final state.
  assign retire = (state_q == S_WB)
                | (state_q == S_MEM  && mem.dmem_ack && cls.store)
                | (state_q == S_EXEC && cls.branch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: doc/risk_ctrl_fsm.md
# risk_ctrl_fsm

Multi-cycle control state machine for the 16-bit RISC core. It sequences instruction fetch, decode, execute, memory access and register write-back. It steers the 5-to-16-bit immediate sign extender onto the ALU B operand and the PC adder, and runs req/ack handshakes with instruction and data memory. It sits beside the datapath and drives every datapath enable and select.

## Interface
- `OPW`, 4: opcode width (instruction bits [15:12]).
- `ALUW`, 3: width of `alu_op`.
- `clk` in 1: the only clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: leave IDLE and start fetching.
- `opcode` in OPW: IR[15:12], valid from the cycle after `ir_load`.
- `alu_zero` in 1: ALU result == 0 (combinational from datapath).
- `imem_ack` in 1: instruction word valid on the bus.
- `dmem_ack` in 1: data read valid / write accepted.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: 1 = store, 0 = load; valid while `dmem_req`.
- `ir_load` out 1: capture instruction into IR.
- `pc_inc` out 1: PC <= PC + 1.
- `pc_load` out 1: PC <= PC + sext(imm5) (branch taken).
- `imm_sel` out 1: ALU B = sign-extended imm5 (else register rt).
- `alu_op` out ALUW: 0 ADD, 1 SUB, 2 AND, 3 OR.
- `rf_we` out 1: register file write enable.
- `wb_sel` out 1: write-back source 1 = memory data, 0 = ALU.
- `halted` out 1: HALT reached; `illegal` out 1: HALT caused by an undefined opcode.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 15 HALT. 8–14 are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters IDLE.
- IDLE: when `run`=1, go to FETCH.
- FETCH: hold `imem_req`=1 until `imem_ack`. In the ack cycle, pulse `ir_load` and `pc_inc` and go to DECODE.
- DECODE: latch `opcode` internally.
  - HALT goes to HALT.
  - An illegal opcode goes to HALT and sets `illegal`.
  - All other opcodes go to EXEC.
- EXEC: drive `alu_op` and `imm_sel`.
  - ADD/SUB/AND/OR: `imm_sel`=0; go to WB.
  - ADDI: ADD with `imm_sel`=1; go to WB.
  - LW/SW: ADD with `imm_sel`=1 to form the address; go to MEM.
  - BEQ: SUB with `imm_sel`=0. `pc_load`=`alu_zero` in this cycle; go to FETCH.
- MEM: hold `dmem_req`=1 (with `dmem_we`=1 for SW) until `dmem_ack`. On ack, LW goes to WB and SW goes to FETCH.
- WB: `rf_we`=1 for one cycle. `wb_sel`=1 only for LW. Go to FETCH.
- HALT: terminal state, left only by reset. `halted`=1.
- All outputs not listed for a state are 0. Outputs are decoded from state and the latched opcode.

## Timing
- Reset: async assertion forces IDLE immediately. Every output is 0, including outstanding requests, which drop the same instant; `illegal` clears.
- Minimum cycles per instruction with ack in the first request cycle:
  - ALU/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - Each ack wait-cycle adds 1.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.
- `pc_inc` and `pc_load` are never both 1. BEQ target arithmetic uses the already-incremented PC.
- `run` is sampled only in IDLE. Deasserting it mid-program has no effect.

## Configuration
- `RISK_CTRL_PERF_EN` defined:
  - Adds output `retired` (16-bit), reset 0.
  - Increments once per completed instruction: the WB exit, SW MEM exit, or BEQ EXEC exit.
  - Wraps 0xFFFF -> 0x0000. HALT is not counted.
- Without the macro, the port and counter do not exist.

## Structure
- Package `risk_ctrl_pkg` holds the opcode localparams, the state enum, and the `alu_op` encodings.
- Sub-module `risk_ctrl_decode` is combinational. It maps the latched opcode to class flags (alu, imm, load, store, branch, halt, illegal) and to `alu_op`.

## Test plan
- Reset then `run`=1, ADD with `imem_ack` immediate: `ir_load`/`pc_inc` in cycle 1, then `alu_op`=0 and `imm_sel`=0 in EXEC, then `rf_we`=1 in cycle 4.
- ADDI then LW with `dmem_ack` delayed 3 cycles: `imm_sel`=1 and `alu_op`=0 in EXEC; `dmem_req` high 4 cycles with `dmem_we`=0; `rf_we`=1 with `wb_sel`=1.
- BEQ twice, with `alu_zero`=1 and then 0: `pc_load`=1 only in the first EXEC; 3 cycles each.
- Opcode 9: `halted`=1 and `illegal`=1. Further `imem_ack`/`run` pulses cause no request and no output change.
- `rst_n` low mid-MEM for SW: `dmem_req` drops asynchronously and state returns to IDLE.
- With `RISK_CTRL_PERF_EN`: 5 mixed instructions then HALT gives `retired`=5. A forced preload of 0xFFFF wraps to 0 after the next retire.
